fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 101 ++++++++++
 tb/tb_fifo_rd_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words from a synchronous-read FIFO into a 3-entry output
// buffer and presents them as a valid/ready stream framed into fixed-length packets.
module fifo_rd_stream #(
   parameter int C_WIDTH   = 32,
   parameter int C_PKT_LEN = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [C_WIDTH-1:0] FIFO_RD_DATA,
   input  logic               FIFO_EMPTY,
   output logic               FIFO_RD_EN,
   output logic [C_WIDTH-1:0] M_DATA,
   output logic               M_VALID,
   input  logic               M_READY,
   output logic               M_LAST,
   output logic [1:0]         BUF_LEVEL
);
   localparam int C_BCW = (C_PKT_LEN > 1) ? $clog2(C_PKT_LEN) : 1;
   localparam logic [C_BCW-1:0] C_LAST_BEAT = C_BCW'(C_PKT_LEN - 1);

   logic [1:0]         r_occ;
   logic               r_inf;
   logic [C_BCW-1:0]   r_bcnt;
   logic [C_WIDTH-1:0] r_buf [3];

   logic [C_WIDTH-1:0] w_buf_nxt [3];
   logic [2:0]         w_fill;
   logic [1:0]         w_occ_nxt;
   logic [1:0]         w_wr_idx;
   logic [C_BCW-1:0]   w_bcnt_nxt;
   logic               w_rd_en;
   logic               w_valid;
   logic               w_pop;

   // Room counts the word already requested, so a read never depends on M_READY.
   assign w_fill   = {1'b0, r_occ} + {2'b00, r_inf};
   assign w_rd_en  = RST_N & ~FIFO_EMPTY & (w_fill <= 3'd2);
   assign w_valid  = RST_N & (r_occ != 2'd0);
   assign w_pop    = w_valid & M_READY;
   assign w_wr_idx = r_occ - {1'b0, w_pop};

   // Buffer next state: shift the head out on pop, then land the returning word at the tail.
   always_comb begin
      for (int i = 0; i < 3; i++) w_buf_nxt[i] = r_buf[i];
      if (w_pop) begin
         w_buf_nxt[0] = r_buf[1];
         w_buf_nxt[1] = r_buf[2];
      end else begin
         w_buf_nxt[0] = r_buf[0];
         w_buf_nxt[1] = r_buf[1];
      end
      if (r_inf) begin
         case (w_wr_idx)
            2'd0:    w_buf_nxt[0] = FIFO_RD_DATA;
            2'd1:    w_buf_nxt[1] = FIFO_RD_DATA;
            2'd2:    w_buf_nxt[2] = FIFO_RD_DATA;
            default: w_buf_nxt[2] = r_buf[2];
         endcase
      end else begin
         w_buf_nxt[2] = r_buf[2];
      end
   end

   // Occupancy and beat counter next state; the beat only advances on a handshake.
   always_comb begin
      w_occ_nxt = r_occ + {1'b0, r_inf} - {1'b0, w_pop};
      if (w_pop) begin
         if (r_bcnt == C_LAST_BEAT) begin
            w_bcnt_nxt = {C_BCW{1'b0}};
         end else begin
            w_bcnt_nxt = r_bcnt + C_BCW'(1'b1);
         end
      end else begin
         w_bcnt_nxt = r_bcnt;
      end
   end

   // Control state with synchronous active-low reset; reset drops buffered and in-flight words.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_occ  <= 2'd0;
         r_inf  <= 1'b0;
         r_bcnt <= {C_BCW{1'b0}};
      end else begin
         r_occ  <= w_occ_nxt;
         r_inf  <= w_rd_en;
         r_bcnt <= w_bcnt_nxt;
      end
   end

   // Data storage carries no reset; contents are meaningless while empty.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= w_buf_nxt[i];
   end

   assign FIFO_RD_EN = w_rd_en;
   assign M_VALID    = w_valid;
   assign M_DATA     = r_buf[0];
   assign M_LAST     = w_valid & (r_bcnt == C_LAST_BEAT);
   assign BUF_LEVEL  = RST_N ? r_occ : 2'd0;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and a scoreboard
// checks stream order, packet framing, stall stability and read-enable legality.
module tb_fifo_rd_stream;
   localparam int PKT = 16;

   logic        clk;
   logic        rst_n;
   logic [31:0] fifo_rd_data;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic [1:0]  buf_level;

   logic [31:0] rd_data1;
   logic        empty1;
   logic        rd_en1;
   logic [31:0] m_data1;
   logic        m_valid1;
   logic        m_ready1;
   logic        m_last1;
   logic [1:0]  buf_level1;

   logic [31:0] mem [2048];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        gap;
   logic        en1;
   int          issued1 = 0;
   logic [31:0] exp_q [$];

   int n_tests = 0;
   int n_fail = 0;
   int beat = 0;
   int hs_total = 0;
   int lasts_seen = 0;
   int last_at = 0;
   int hs1 = 0;
   int total_written = 0;

   fifo_rd_stream #(.C_WIDTH(32), .C_PKT_LEN(PKT)) dut (
      .CLK(clk), .RST_N(rst_n), .FIFO_RD_DATA(fifo_rd_data), .FIFO_EMPTY(fifo_empty),
      .FIFO_RD_EN(fifo_rd_en), .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready),
      .M_LAST(m_last), .BUF_LEVEL(buf_level));

   fifo_rd_stream #(.C_WIDTH(32), .C_PKT_LEN(1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .FIFO_RD_DATA(rd_data1), .FIFO_EMPTY(empty1),
      .FIFO_RD_EN(rd_en1), .M_DATA(m_data1), .M_VALID(m_valid1), .M_READY(m_ready1),
      .M_LAST(m_last1), .BUF_LEVEL(buf_level1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = gap | (rd_ptr == wr_ptr);
   assign empty1     = ~en1 | (issued1 >= 4);

   // Synchronous-read FIFO models: data appears the cycle after an accepted read.
   always @(posedge clk) begin
      if (fifo_rd_en && rd_ptr != wr_ptr) begin
         fifo_rd_data <= mem[rd_ptr];
         exp_q.push_back(mem[rd_ptr]);
         rd_ptr <= rd_ptr + 1;
      end
      if (rd_en1) begin
         rd_data1 <= 32'h100 + 32'(issued1);
         issued1 <= issued1 + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] v);
      mem[wr_ptr] = v;
      wr_ptr++;
      total_written++;
   endtask

   task automatic drain(input int max_cyc);
      int quiet = 0;
      for (int c = 0; c < max_cyc && quiet < 3; c++) begin
         @(negedge clk);
         if (fifo_empty && !m_valid && exp_q.size() == 0) quiet++;
         else quiet = 0;
      end
   endtask

   // Scoreboard: every handshake must deliver the next FIFO word with the right framing.
   initial begin
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = 32'd0;
      logic        prev_last = 1'b0;
      logic [31:0] w;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 1'b0);
            if (prev_stall) begin
               chk("stall_valid", m_valid, 1'b1);
               chk("stall_data", m_data, prev_data);
               chk("stall_last", m_last, prev_last);
            end
            chk("last_flag", m_last, (m_valid && beat == PKT - 1));
            if (m_valid && m_ready) begin
               chk("word_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk("data_order", m_data, w);
                  beat = (beat + 1) % PKT;
                  hs_total++;
                  if (m_last) begin
                     lasts_seen++;
                     last_at = hs_total;
                  end
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            chk("len1_rd_en_while_empty", rd_en1 & empty1, 1'b0);
            if (m_valid1 && m_ready1) begin
               chk("len1_last", m_last1, 1'b1);
               chk("len1_data", m_data1, 32'h100 + 32'(hs1));
               hs1++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_rd, first_vld, n, pulses, base, pushed;
      rst_n = 1'b0; m_ready = 1'b0; gap = 1'b0; en1 = 1'b0; m_ready1 = 1'b0;
      for (int i = 1; i <= 32; i++) push_word(32'(i));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_level", buf_level, 2'd0);
      chk("len1_rst_level", buf_level1, 2'd0);

      // Preloaded 32 words with M_READY high: back-to-back beats, last on 0x10 and 0x20.
      m_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      first_rd = -1; first_vld = -1;
      for (int c = 0; c < 20 && first_vld < 0; c++) begin
         @(negedge clk);
         if (fifo_rd_en && first_rd < 0) first_rd = c;
         if (m_valid) first_vld = c;
      end
      // Word returns the cycle after the request and is presented from the buffer the next.
      chk("first_valid_after_rd_en", first_vld - first_rd, 2);
      n = 0;
      while (m_valid && n < 60) begin
         n++;
         @(negedge clk);
      end
      chk("consecutive_beats", n, 32);
      chk("t1_lasts", lasts_seen, 2);
      chk("t1_words_left", exp_q.size(), 0);

      // Single-word packets: every beat is last.
      @(posedge clk); #1 en1 = 1'b1; m_ready1 = 1'b1;
      for (int c = 0; c < 30 && hs1 < 4; c++) @(negedge clk);
      chk("len1_beats", hs1, 4);

      // Stalled sink: exactly three reads fill the buffer, then reads stop.
      @(posedge clk); #1 m_ready = 1'b0;
      base = hs_total;
      for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
      end
      chk("stall_rd_pulses", pulses, 3);
      chk("stall_level", buf_level, 2'd3);
      chk("stall_rd_en_low", fifo_rd_en, 1'b0);
      @(posedge clk); #1 m_ready = 1'b1;
      drain(60);
      chk("stall_drain_count", hs_total - base, 8);

      // Reset with two buffered and one in-flight word: all three are lost.
      @(posedge clk); #1 m_ready = 1'b0;
      for (int i = 0; i < 19; i++) push_word(32'h300 + 32'(i));
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      chk("pre_reset_level", buf_level, 2'd2);
      rst_n = 1'b0;
      exp_q.delete();
      beat = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      base = hs_total;
      @(negedge clk);
      chk("post_reset_valid", m_valid, 1'b0);
      chk("post_reset_level", buf_level, 2'd0);
      @(posedge clk); #1 m_ready = 1'b1;
      drain(80);
      chk("post_reset_last_index", last_at - base, 16);
      chk("post_reset_count", hs_total - base, 16);

      // FIFO runs dry after beat 5, refills later: packet resumes and ends on the 11th word.
      base = hs_total;
      for (int i = 0; i < 5; i++) push_word(32'h400 + 32'(i));
      drain(40);
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) push_word(32'h500 + 32'(i));
      drain(60);
      chk("refill_last_index", last_at - base, 16);
      chk("refill_count", hs_total - base, 16);

      // Random sink back-pressure and FIFO gaps over 1000 words.
      base = hs_total;
      pushed = 0;
      for (int c = 0; c < 20000 && (hs_total - base) < 1000; c++) begin
         @(posedge clk); #1;
         m_ready = 1'($urandom_range(0, 1));
         gap = ($urandom_range(0, 3) == 0);
         if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
            push_word($urandom);
            pushed++;
         end
      end
      gap = 1'b0; m_ready = 1'b1;
      drain(40);
      chk("random_delivered", hs_total - base, 1000);
      chk("random_leftover", exp_q.size(), 0);
      chk("fifo_drained", rd_ptr, wr_ptr);
      chk("total_delivered", hs_total, total_written - 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
